dsec_stream_ctrl: RTL

- Parametrised, FSM-based control for the data stream compression/encryption (DSEC) top level.
- Gates input into the compression module and drives stall to the compression, encryption and shift-concatenation datapath.
- Holds out_valid under a true valid/received handshake, supports an end-of-stream flush, and records sticky error codes.
- Counts words delivered.

---
 rtl/dsec_ctrl_pkg.sv | 43 ++++
 rtl/dsec_err_latch.sv | 40 ++++
 rtl/dsec_stream_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dsec_ctrl_pkg.sv
// DSEC stream control shared types: FSM states, error codes, default widths.
// Exports state_e, err_det_t, ERR_* codes and err_pick() (first-error priority).
package dsec_ctrl_pkg;

    localparam int VBITS_W_DEF = 7;
    localparam int ERR_W_DEF   = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int WDOG_W_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_FLUSH,
        ST_KEYCFG,
        ST_ERR
    } state_e;

    localparam logic [7:0] ERR_NONE      = 8'h00;
    localparam logic [7:0] ERR_IN_OVR    = 8'h01;
    localparam logic [7:0] ERR_OUT_OVR   = 8'h02;
    localparam logic [7:0] ERR_FLUSH_KEY = 8'h03;
    localparam logic [7:0] ERR_WDOG      = 8'h04;

    typedef struct packed {
        logic wdog;
        logic flush_key;
        logic out_ovr;
        logic in_ovr;
    } err_det_t;

    // Lowest code wins when several errors fire in the same cycle.
    function automatic logic [7:0] err_pick(input err_det_t d);
        logic [7:0] c;
        c = ERR_NONE;
        if (d.in_ovr)         c = ERR_IN_OVR;
        else if (d.out_ovr)   c = ERR_OUT_OVR;
        else if (d.flush_key) c = ERR_FLUSH_KEY;
        else if (d.wdog)      c = ERR_WDOG;
        return c;
    endfunction

endpackage

// File: rtl/dsec_err_latch.sv
// Sticky first-error capture for the DSEC controller.
// Ports: clk, rst (async low), clr_i, det_i -> set_o (new capture), error_o, code_o.
module dsec_err_latch
    import dsec_ctrl_pkg::*;
#(
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  err_det_t         det_i,
    output logic             set_o,
    output logic             error_o,
    output logic [ERR_W-1:0] code_o
);

    logic             error_q;
    logic [ERR_W-1:0] code_q;
    logic [7:0]       pick;

    assign pick    = err_pick(det_i);
    // Clear beats a simultaneous new error; only the first error is kept.
    assign set_o   = (|det_i) & ~error_q & ~clr_i;
    assign error_o = error_q;
    assign code_o  = code_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_q <= 1'b0;
            code_q  <= '0;
        end else if (clr_i) begin
            error_q <= 1'b0;
            code_q  <= '0;
        end else if (set_o) begin
            error_q <= 1'b1;
            code_q  <= ERR_W'(pick);
        end
    end

endmodule

// File: rtl/dsec_stream_ctrl.sv
// DSEC top-level stream control FSM: input gating, datapath stall, output
// handshake, end-of-stream flush, sticky errors and delivered-word count.
// Inputs: clk, rst (async low), key_config, in_valid, comp_rdy, scon_done,
//   valid_bits, flush_req, out_rcvd, err_clr.
// Outputs: stall, rdy, valid_to_comp, dump_comp, out_valid, last_word,
//   error, error_code, words_out.
// Option: define DSEC_WDOG_EN to add the output-hold watchdog (code 0x04).
module dsec_stream_ctrl
    import dsec_ctrl_pkg::*;
#(
    parameter int VBITS_W = VBITS_W_DEF,
    parameter int ERR_W   = ERR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WDOG_W  = WDOG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_config,
    input  logic               in_valid,
    input  logic               comp_rdy,
    input  logic               scon_done,
    input  logic [VBITS_W-1:0] valid_bits,
    input  logic               flush_req,
    input  logic               out_rcvd,
    input  logic               err_clr,
    output logic               stall,
    output logic               rdy,
    output logic               valid_to_comp,
    output logic               dump_comp,
    output logic               out_valid,
    output logic               last_word,
    output logic               error,
    output logic [ERR_W-1:0]   error_code,
    output logic [CNT_W-1:0]   words_out
);

    state_e           state_q;
    logic             out_valid_q;
    logic             last_word_q;
    logic             flush_pend_q;
    // Flush entered with no bits left: pass through FLUSH/HOLD, no word.
    logic             empty_q;
    logic [CNT_W-1:0] words_q;
    logic             err_set;
    logic             tail;
    logic             vb_zero;
    err_det_t         det;

    assign tail    = last_word_q | empty_q;
    assign vb_zero = (valid_bits == '0);

    assign stall = (state_q == ST_KEYCFG) | key_config | error;
    assign rdy   = comp_rdy & ~stall & (state_q != ST_FLUSH)
                 & ~((state_q == ST_HOLD) & tail);
    assign valid_to_comp = in_valid & rdy;
    assign dump_comp     = (state_q == ST_FLUSH) & ~empty_q;
    assign out_valid     = out_valid_q;
    assign last_word     = last_word_q;
    assign words_out     = words_q;

`ifdef DSEC_WDOG_EN
    logic [WDOG_W-1:0] wdog_q;

    // Restarts on every HOLD entry and on each accepted word;
    // a key_config stall freezes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (state_q != ST_HOLD || out_rcvd) begin
            wdog_q <= '0;
        end else if (!key_config && !(&wdog_q)) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`endif

    always_comb begin
        det           = '0;
        det.in_ovr    = in_valid & ~rdy & ~stall;
        det.out_ovr   = scon_done & out_valid_q & ~out_rcvd;
        det.flush_key = flush_req & key_config;
`ifdef DSEC_WDOG_EN
        det.wdog      = (state_q == ST_HOLD) & ~empty_q
                      & (&wdog_q) & ~out_rcvd;
`endif
    end

    dsec_err_latch #(
        .ERR_W(ERR_W)
    ) u_err (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (err_clr),
        .det_i   (det),
        .set_o   (err_set),
        .error_o (error),
        .code_o  (error_code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            last_word_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            empty_q      <= 1'b0;
            words_q      <= '0;
        end else begin
            if (out_valid_q && out_rcvd) begin
                words_q <= words_q + 1'b1;
            end

            if (err_set) begin
                state_q <= ST_ERR;
                if (out_rcvd) out_valid_q <= 1'b0;
            end else if (key_config && state_q != ST_ERR) begin
                // Key reload drops any pending output.
                state_q      <= ST_KEYCFG;
                out_valid_q  <= 1'b0;
                last_word_q  <= 1'b0;
                flush_pend_q <= 1'b0;
                empty_q      <= 1'b0;
            end else begin
                if (out_rcvd) out_valid_q <= 1'b0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (in_valid) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (scon_done) begin
                            state_q      <= ST_HOLD;
                            out_valid_q  <= 1'b1;
                            flush_pend_q <= flush_req;
                        end else if (flush_req) begin
                            state_q <= ST_FLUSH;
                            empty_q <= vb_zero;
                        end
                    end
                    ST_HOLD: begin
                        if (empty_q) begin
                            state_q <= ST_IDLE;
                            empty_q <= 1'b0;
                        end else begin
                            if (flush_req && !last_word_q) flush_pend_q <= 1'b1;
                            if (out_rcvd) begin
                                if (last_word_q) begin
                                    state_q     <= ST_IDLE;
                                    last_word_q <= 1'b0;
                                end else if (flush_pend_q || flush_req) begin
                                    state_q      <= ST_FLUSH;
                                    flush_pend_q <= 1'b0;
                                    empty_q      <= vb_zero;
                                end else if (scon_done) begin
                                    // Next word ready as this one leaves.
                                    out_valid_q <= 1'b1;
                                end else begin
                                    state_q <= ST_RUN;
                                end
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (empty_q) begin
                            state_q <= ST_HOLD;
                        end else if (scon_done) begin
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                            last_word_q <= 1'b1;
                        end
                    end
                    ST_KEYCFG: begin
                        state_q <= ST_IDLE;
                    end
                    ST_ERR: begin
                        if (err_clr) begin
                            state_q      <= ST_IDLE;
                            out_valid_q  <= 1'b0;
                            last_word_q  <= 1'b0;
                            flush_pend_q <= 1'b0;
                            empty_q      <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
